// File: rtl/mode_pkg.sv
// mode_pkg -- shared definitions for the pacing-mode frame.
//
// Used by both the mode transmitter (mode_sender) and the mode-configuration
// receiver so the two ends agree on field widths, flag bit positions and the
// power-up mode.
//
// Frame layout (byte0 goes out first):
//   byte0 = SA_rest[7:0]
//   byte1 = {pace_en, SA_rest[14:8]}
//   byte2 = AV_forw[7:0]
//   byte3 = {PVCen, PACen, AV_forw[13:8]}
package mode_pkg;

    localparam int NUM_BYTES   = 4;
    localparam int SA_REST_W   = 15;
    localparam int AV_FORW_W   = 14;

    // Flag positions inside their bytes
    localparam int PACE_EN_BIT = 7;   // byte1
    localparam int PACEN_BIT   = 6;   // byte3
    localparam int PVCEN_BIT   = 7;   // byte3

    // Power-up / default pacing mode
    localparam logic [SA_REST_W-1:0] DEF_SA_REST = 15'd900;
    localparam logic                 DEF_PACE_EN = 1'b1;
    localparam logic [AV_FORW_W-1:0] DEF_AV_FORW = 14'd50;
    localparam logic                 DEF_PACEN   = 1'b0;
    localparam logic                 DEF_PVCEN   = 1'b0;

    // Frame-level sequencer states
    typedef enum logic {
        S_IDLE,
        S_SEND
    } send_state_t;

    // Per-byte UART shifter states
    typedef enum logic [1:0] {
        B_IDLE,
        B_START,
        B_DATA,
        B_STOP
    } byte_state_t;

    // Pack the mode fields into the 32-bit frame, byte0 in bits [7:0].
    function automatic logic [8*NUM_BYTES-1:0] pack_frame(
        input logic [SA_REST_W-1:0] sa_rest,
        input logic                 pace_en,
        input logic [AV_FORW_W-1:0] av_forw,
        input logic                 pacen,
        input logic                 pvcen
    );
        logic [7:0] b0, b1, b2, b3;
        b0 = sa_rest[7:0];
        b1 = {1'b0, sa_rest[SA_REST_W-1:8]};
        b1[PACE_EN_BIT] = pace_en;
        b2 = av_forw[7:0];
        b3 = {2'b00, av_forw[AV_FORW_W-1:8]};
        b3[PACEN_BIT] = pacen;
        b3[PVCEN_BIT] = pvcen;
        return {b3, b2, b1, b0};
    endfunction

endpackage

// File: rtl/serial_byte_tx.sv
// serial_byte_tx -- one-byte 8N1 UART shifter (start, 8 data LSB first, stop).
//
// Ports:
//   clk    in   clock, rising edge
//   rst    in   synchronous active-high reset (line returns high)
//   load   in   accept 'data' when ready is high
//   data   in   8  byte to send
//   ready  out  high in idle and during the final cycle of the stop bit, so a
//               new byte can be chained with no gap on the line
//   tx     out  serial line, idles high
//
// Handshake: a byte is taken on a rising edge where load && ready; the start
// bit appears on the line the cycle after. Each bit lasts BAUD_DIV cycles.
module serial_byte_tx
    import mode_pkg::*;
#(
    parameter int BAUD_DIV = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [7:0] data,
    output logic       ready,
    output logic       tx
);

    localparam int CW = $clog2(BAUD_DIV);

    byte_state_t   state, state_next;
    logic [CW-1:0] cnt, cnt_next;
    logic [2:0]    bit_idx, bit_next;
    logic [7:0]    shreg, shreg_next;
    logic          bit_end;

    assign bit_end = (cnt == CW'(BAUD_DIV - 1));

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        bit_next   = bit_idx;
        shreg_next = shreg;
        ready      = 1'b0;
        tx         = 1'b1;

        case (state)
            B_IDLE: begin
                ready = 1'b1;
            end
            B_START: begin
                tx = 1'b0;
                if (bit_end) begin
                    cnt_next   = '0;
                    bit_next   = '0;
                    state_next = B_DATA;
                end else begin
                    cnt_next = cnt + 1'b1;
                end
            end
            B_DATA: begin
                tx = shreg[0];
                if (bit_end) begin
                    cnt_next   = '0;
                    shreg_next = shreg >> 1;
                    if (bit_idx == 3'd7) begin
                        state_next = B_STOP;
                    end else begin
                        bit_next = bit_idx + 1'b1;
                    end
                end else begin
                    cnt_next = cnt + 1'b1;
                end
            end
            B_STOP: begin
                if (bit_end) begin
                    // Last stop-bit cycle: allow the next byte to follow back-to-back.
                    ready      = 1'b1;
                    cnt_next   = '0;
                    state_next = B_IDLE;
                end else begin
                    cnt_next = cnt + 1'b1;
                end
            end
            default: state_next = B_IDLE;
        endcase

        if (load && ready) begin
            state_next = B_START;
            cnt_next   = '0;
            bit_next   = '0;
            shreg_next = data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= B_IDLE;
            cnt     <= '0;
            bit_idx <= '0;
            shreg   <= '0;
        end else begin
            state   <= state_next;
            cnt     <= cnt_next;
            bit_idx <= bit_next;
            shreg   <= shreg_next;
        end
    end

endmodule

// File: rtl/mode_sender.sv
// mode_sender -- transmits the 32-bit pacing-mode frame as four 8N1 bytes.
//
// Optional feature macro: MODE_SENDER_RANGE_CHECK_EN
//   defined   : a request with SA_rest[15]=1 or AV_forw[15:14]!=0 is rejected
//               with a one-cycle err pulse and nothing is sent.
//   undefined : out-of-range bits are masked off and err is tied low.
//
// Ports:
//   clk_fast  in   clock, rising edge
//   rst       in   synchronous active-high reset; abandons any frame in flight
//   send      in   transmit request, sampled only while idle
//   SA_rest   in   16  SA rest period (bits [14:0] sent)
//   pace_en   in   pacing enable
//   AV_forw   in   16  AV forward delay (bits [13:0] sent)
//   PACen     in   PAC enable
//   PVCen     in   PVC enable
//   tx        out  serial line, idles high
//   busy      out  high while a frame is on the line
//   done      out  one-cycle pulse in the cycle after the last stop bit
//   err       out  one-cycle reject pulse (range-check builds only)
//
// Request timing: send seen at edge N latches the inputs into the frame
// register; at edge N+1 the first byte is launched (busy=1, start bit on tx)
// or, for a rejected request, err is raised. Sends while a request is pending
// or while busy are ignored.
module mode_sender
    import mode_pkg::*;
#(
    parameter int CLK_FREQ = 50000000,
    parameter int BAUD     = 115200
) (
    input  logic        clk_fast,
    input  logic        rst,
    input  logic        send,
    input  logic [15:0] SA_rest,
    input  logic        pace_en,
    input  logic [15:0] AV_forw,
    input  logic        PACen,
    input  logic        PVCen,
    output logic        tx,
    output logic        busy,
    output logic        done,
    output logic        err
);

    localparam int BAUD_DIV = CLK_FREQ / BAUD;
    localparam int FW       = 8 * NUM_BYTES;
    localparam int IW       = $clog2(NUM_BYTES);

    send_state_t   state, state_next;
    logic [IW-1:0] idx, idx_next;
    logic          req_q, req_next;
    logic [FW-1:0] frame, frame_next;
    logic          done_q, done_next;
    logic          byte_load;
    logic [7:0]    byte_data;
    logic          byte_ready;
    logic          req_ok;

`ifdef MODE_SENDER_RANGE_CHECK_EN
    logic bad_q, bad_next;
    logic err_q, err_next;
    logic in_range;

    assign in_range = !SA_rest[15] && (AV_forw[15:14] == 2'b00);
    assign req_ok   = !bad_q;
    assign err      = err_q;
`else
    logic unused_range_bits;

    assign unused_range_bits = ^{SA_rest[15], AV_forw[15:14]};
    assign req_ok            = 1'b1;
    assign err               = 1'b0;
`endif

    always_comb begin
        state_next = state;
        idx_next   = idx;
        req_next   = 1'b0;
        frame_next = frame;
        done_next  = 1'b0;
        byte_load  = 1'b0;
        byte_data  = frame[7:0];
`ifdef MODE_SENDER_RANGE_CHECK_EN
        bad_next   = bad_q;
        err_next   = 1'b0;
`endif

        case (state)
            S_IDLE: begin
                if (req_q) begin
                    // Second half of the accept: launch byte0 or reject.
                    if (req_ok) begin
                        byte_load  = 1'b1;
                        byte_data  = frame[7:0];
                        idx_next   = '0;
                        state_next = S_SEND;
                    end
`ifdef MODE_SENDER_RANGE_CHECK_EN
                    else begin
                        err_next = 1'b1;
                    end
`endif
                end else if (send) begin
                    req_next   = 1'b1;
                    frame_next = pack_frame(SA_rest[SA_REST_W-1:0], pace_en,
                                            AV_forw[AV_FORW_W-1:0], PACen, PVCen);
`ifdef MODE_SENDER_RANGE_CHECK_EN
                    bad_next   = !in_range;
`endif
                end
            end
            S_SEND: begin
                // byte_ready here means the current stop bit is in its last cycle.
                if (byte_ready) begin
                    if (idx == IW'(NUM_BYTES - 1)) begin
                        state_next = S_IDLE;
                        done_next  = 1'b1;
                    end else begin
                        idx_next  = idx + 1'b1;
                        byte_load = 1'b1;
                        byte_data = frame[{idx_next, 3'b000} +: 8];
                    end
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_fast) begin
        if (rst) begin
            state  <= S_IDLE;
            idx    <= '0;
            req_q  <= 1'b0;
            frame  <= pack_frame(DEF_SA_REST, DEF_PACE_EN, DEF_AV_FORW, DEF_PACEN, DEF_PVCEN);
            done_q <= 1'b0;
`ifdef MODE_SENDER_RANGE_CHECK_EN
            bad_q  <= 1'b0;
            err_q  <= 1'b0;
`endif
        end else begin
            state  <= state_next;
            idx    <= idx_next;
            req_q  <= req_next;
            frame  <= frame_next;
            done_q <= done_next;
`ifdef MODE_SENDER_RANGE_CHECK_EN
            bad_q  <= bad_next;
            err_q  <= err_next;
`endif
        end
    end

    assign busy = (state == S_SEND);
    assign done = done_q;

    serial_byte_tx #(
        .BAUD_DIV(BAUD_DIV)
    ) u_byte_tx (
        .clk  (clk_fast),
        .rst  (rst),
        .load (byte_load),
        .data (byte_data),
        .ready(byte_ready),
        .tx   (tx)
    );

endmodule
